// File: rtl/ym3016_serial_tx_if.sv
// Handshake and serial-stream bundle between a PCM source and the YM3016 transmitter.
interface ym3016_serial_tx_if;
  logic        enable;
  logic [15:0] pcm_l;
  logic [15:0] pcm_r;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        frame_start;
  logic        underrun;
  logic        dac_clk;
  logic        dac_so;
  logic        dac_sh1;
  logic        dac_sh2;

  modport master (
    output enable, pcm_l, pcm_r, pcm_valid,
    input  pcm_ready, frame_start, underrun, dac_clk, dac_so, dac_sh1, dac_sh2
  );

  modport slave (
    input  enable, pcm_l, pcm_r, pcm_valid,
    output pcm_ready, frame_start, underrun, dac_clk, dac_so, dac_sh1, dac_sh2
  );
endinterface

// File: rtl/ym3016_serial_tx.sv
// YM2610-style serial DAC stream generator: 16-bit stereo PCM in, YM3016
// floating-point (10-bit mantissa, 3-bit exponent) bit stream out.
//
// state | meaning
// IDLE  | stream stopped, divider held at 0, serial outputs low
// START | divider running, waiting for the first rise (enters b=0)
// RUN   | frame in progress, bit counter advances on each dac_clk rise
module ym3016_serial_tx #(
  parameter int HALF_DIV = 6
) (
  input  logic             clk_24m,
  input  logic             rst,
  ym3016_serial_tx_if.slave bus
);

  localparam logic [7:0]         DIV_TC   = 8'(HALF_DIV - 1);
  localparam logic signed [15:0] MANT_MIN = -16'sd512;
  localparam logic signed [15:0] MANT_MAX = 16'sd511;

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div;
  logic [4:0]  bcnt;
  logic [4:0]  bcnt_nxt;
  logic        clk_q, so_q, sh1_q, sh2_q, fs_q, ur_q;
  logic [15:0] hold_l, hold_r, last_l, last_r;
  logic        hold_full;
  logic [31:0] sreg;
  logic        tc, rise_en, fall_en;
  logic        do_load, do_adv, do_stop;
  logic        accept;
  logic [15:0] src_l, src_r;
  logic [31:0] frame_word;

  // One 16-bit slot, bit 0 sent first: {e[2:0], m[9:0], 3'b000}.
  function automatic logic [15:0] encode_slot(input logic [15:0] s);
    logic [15:0] t;
    logic [9:0]  m;
    logic [2:0]  e;
    logic        found;
    m     = '0;
    e     = 3'd7;
    found = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      t = 16'($signed(s) >>> (i - 1));
      if (!found && ($signed(t) >= MANT_MIN) && ($signed(t) <= MANT_MAX)) begin
        found = 1'b1;
        e     = 3'(i);
        m     = t[9:0];
      end
    end
    return {e, m, 3'b000};
  endfunction

  assign tc         = (div == DIV_TC);
  assign rise_en    = (state != IDLE) && tc && !clk_q;
  assign fall_en    = (state != IDLE) && tc && clk_q;
  assign accept     = bus.pcm_valid && !hold_full;
  assign src_l      = hold_full ? hold_l : last_l;
  assign src_r      = hold_full ? hold_r : last_r;
  assign frame_word = {encode_slot(src_r), encode_slot(src_l)};
  assign bcnt_nxt   = bcnt + 5'd1;

  // State register.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; enable is only sampled at frame boundaries once running.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_adv    = 1'b0;
    do_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) state_nxt = START;
      end
      START: begin
        if (rise_en) begin
          if (bus.enable) begin
            state_nxt = RUN;
            do_load   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RUN: begin
        if (rise_en) begin
          if (bcnt != 5'd31) begin
            do_adv = 1'b1;
          end else if (bus.enable) begin
            do_load = 1'b1;
          end else begin
            state_nxt = IDLE;
            do_stop   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Half-period divider; held at 0 whenever the stream is stopped.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst)                                     div <= '0;
    else if (state == IDLE || state_nxt == IDLE) div <= '0;
    else if (tc)                                 div <= '0;
    else                                         div <= div + 8'd1;
  end

  // Serial outputs; data and strobes only move on the dac_clk rise.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      clk_q  <= 1'b0;
      so_q   <= 1'b0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
      fs_q   <= 1'b0;
      ur_q   <= 1'b0;
      bcnt   <= '0;
      sreg   <= '0;
      last_l <= '0;
      last_r <= '0;
    end else begin
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      if (fall_en) clk_q <= 1'b0;
      if (do_load) begin
        clk_q  <= 1'b1;
        bcnt   <= '0;
        so_q   <= frame_word[0];
        sreg   <= {1'b0, frame_word[31:1]};
        sh1_q  <= 1'b0;
        sh2_q  <= 1'b0;
        last_l <= src_l;
        last_r <= src_r;
        fs_q   <= 1'b1;
        ur_q   <= !hold_full;
      end else if (do_adv) begin
        clk_q <= 1'b1;
        bcnt  <= bcnt_nxt;
        so_q  <= sreg[0];
        sreg  <= {1'b0, sreg[31:1]};
        sh1_q <= (bcnt_nxt >= 5'd3) && (bcnt_nxt <= 5'd15);
        sh2_q <= (bcnt_nxt >= 5'd19);
      end else if (do_stop) begin
        so_q  <= 1'b0;
        sh1_q <= 1'b0;
        sh2_q <= 1'b0;
        bcnt  <= '0;
        sreg  <= '0;
      end
    end
  end

  // Single-entry holding register; a load at the boundary frees it.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_l    <= bus.pcm_l;
      hold_r    <= bus.pcm_r;
      hold_full <= 1'b1;
    end else if (do_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  assign bus.pcm_ready   = !hold_full;
  assign bus.frame_start = fs_q;
  assign bus.underrun    = ur_q;
  assign bus.dac_clk     = clk_q;
  assign bus.dac_so      = so_q;
  assign bus.dac_sh1     = sh1_q;
  assign bus.dac_sh2     = sh2_q;

endmodule
